game_round_scheduler: RTL and testbench
=======================================

# game_round_scheduler

Match controller for the multi-mode game counter. It loads the counter at the start of each match, shares the counter's 2-bit mode control between two players (A and B) by round-robin turns, credits WINNER/LOSER pulses to the player holding the turn, and declares a champion when the counter signals GAMEOVER or a score saturates. It sits directly above the counter instance: its `ctr_*` outputs drive the counter's ctrl/INIT/loadValue, and the counter's flags feed back into it.

## Interface
- COUNTER_SIZE, 4, width of the counter load value
- TURN_LEN, 4, cycles per granted turn (≥1)
- SCORE_W, 4, width of each player score

- clk  in  1  clock, rising edge
- rst_l  in  1  reset, synchronous, active-low
- start  in  1  begin match (sampled in IDLE/OVER only)
- seed_value  in  COUNTER_SIZE  value loaded into counter at match start
- a_req / b_req  in  1  player requests a turn (level)
- a_mode / b_mode  in  2  requested counter mode (00 +1, 01 +2, 10 −1, 11 −2)
- a_gnt / b_gnt  out  1  one-cycle turn-grant pulse
- ctr_ctrl  out  2  counter mode control
- ctr_init  out  1  counter INIT
- ctr_load  out  COUNTER_SIZE  counter loadValue
- ctr_winner / ctr_loser / ctr_gameover  in  1  counter WINNER / LOSER / GAMEOVER
- a_score / b_score  out  SCORE_W  match scores
- owner  out  2  turn holder: 00 none, 01 A, 10 B
- busy  out  1  match in progress (LOAD/ARB/TURN)
- done  out  1  one-cycle pulse on entering OVER
- champion  out  2  00 none, 01 A, 10 B, 11 tie; valid in OVER

## Operation
- All outputs registered. Reset (rst_l=0 at an edge): state IDLE; every output 0; turn counter and rr pointer (points to A) cleared.
- States: IDLE, LOAD, ARB, TURN, OVER.
- IDLE: outputs at reset values. start=1 → LOAD.
- LOAD (1 cycle): ctr_init=1, ctr_load=seed_value, scores cleared, owner=00, champion=00, busy=1 → ARB. ctr_init is 0 in every other state.
- ARB: both requests → grant the player the rr pointer selects, then move pointer to the other; one request → grant it regardless of pointer; none → stay in ARB, ctr_ctrl holds its last value. On grant: that gnt=1 for one cycle, ctr_ctrl ← granted player's mode, owner ← player, turn counter ← TURN_LEN−1 → TURN.
- TURN: mode fixed; requests ignored; turn counter decrements each cycle; at 0 → ARB (owner kept until next grant).
- Scoring, in ARB and TURN: ctr_winner=1 → owner's score +1; ctr_loser=1 → the other player's score +1; owner=00 → ignored. Scores saturate at 2^SCORE_W−1.
- End of match: ctr_gameover=1, or either score reaching 2^SCORE_W−1 (including via this cycle's increment) → OVER. A flag arriving in the same cycle as ctr_gameover is scored first.
- OVER: done=1 for first cycle; champion = higher score (01/10), 11 if equal; busy=0; scores and champion held; start=1 → LOAD.
- start while busy: ignored.

## Timing
- start at edge N → ctr_init=1 during cycle N+1 → ARB at N+2.
- Grant decided at the first edge in ARB with any req high; gnt, ctr_ctrl, owner all update at that same edge.
- A turn lasts exactly TURN_LEN cycles in TURN, then ≥1 cycle in ARB before the next grant. Back-to-back turns with continuous requests: grants every TURN_LEN+1 cycles, alternating A/B.
- Counter flags are scored at the edge that samples them (score visible next cycle).
- Reset mid-match overrides everything at that edge; counter is re-initialised only by the next LOAD.

## Test plan
- Reset mid-TURN with a_score=3 → next cycle all outputs 0, state IDLE; start then gives ctr_init=1 for exactly one cycle with ctr_load=seed_value=9.
- a_req=b_req=1 continuously, a_mode=00, b_mode=11, TURN_LEN=4 → grants A,B,A,B five cycles apart; ctr_ctrl alternates 00/11; only one gnt high per pulse.
- Only b_req=1 with rr pointer at A → b_gnt immediately; pointer not consumed by the A preference.
- owner=A, ctr_winner pulse → a_score+1; ctr_loser pulse → b_score+1; flag with owner=00 after LOAD → no change.
- a_score=14, ctr_winner under A (SCORE_W=4) → a_score=15, done pulse, champion=01; further flags ignored.
- ctr_gameover with equal scores 3/3 → OVER, champion=11, busy=0; start while busy earlier had no effect.

Source files
------------

// File: rtl/game_round_scheduler.sv
// Match controller above the multi-mode game counter: loads the counter, round-robins its
// mode control between players A and B, scores WINNER/LOSER flags and declares a champion.
module game_round_scheduler #(
  parameter int unsigned COUNTER_SIZE = 4,
  parameter int unsigned TURN_LEN     = 4,
  parameter int unsigned SCORE_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    start,
  input  logic [COUNTER_SIZE-1:0] seed_value,
  input  logic                    a_req,
  input  logic                    b_req,
  input  logic [1:0]              a_mode,
  input  logic [1:0]              b_mode,
  output logic                    a_gnt,
  output logic                    b_gnt,
  output logic [1:0]              ctr_ctrl,
  output logic                    ctr_init,
  output logic [COUNTER_SIZE-1:0] ctr_load,
  input  logic                    ctr_winner,
  input  logic                    ctr_loser,
  input  logic                    ctr_gameover,
  output logic [SCORE_W-1:0]      a_score,
  output logic [SCORE_W-1:0]      b_score,
  output logic [1:0]              owner,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              champion
);

  localparam int unsigned CntW = (TURN_LEN > 1) ? $clog2(TURN_LEN) : 1;
  localparam logic [CntW-1:0] TurnLast = CntW'(TURN_LEN - 1);
  localparam logic [SCORE_W-1:0] ScoreMax = '1;

  localparam logic [1:0] OwnNone = 2'b00;
  localparam logic [1:0] OwnA    = 2'b01;
  localparam logic [1:0] OwnB    = 2'b10;
  localparam logic [1:0] OwnTie  = 2'b11;

  typedef enum logic [2:0] {StIdle, StLoad, StArb, StTurn, StOver} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    rr_b_q, rr_b_d;  // round-robin pointer: 0 favours A, 1 favours B
  logic                    a_gnt_q, a_gnt_d;
  logic                    b_gnt_q, b_gnt_d;
  logic [1:0]              ctrl_q, ctrl_d;
  logic                    init_q, init_d;
  logic [COUNTER_SIZE-1:0] load_q, load_d;
  logic [SCORE_W-1:0]      a_score_q, a_score_d;
  logic [SCORE_W-1:0]      b_score_q, b_score_d;
  logic [1:0]              owner_q, owner_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [1:0]              champ_q, champ_d;

  logic               credit_a, credit_b;
  logic [SCORE_W-1:0] a_sc_next, b_sc_next;
  logic               match_end;
  logic               grant_a, grant_b;

  // WINNER credits the turn holder, LOSER credits the opponent; no holder means no credit.
  always_comb begin
    credit_a = ((owner_q == OwnA) && ctr_winner) || ((owner_q == OwnB) && ctr_loser);
    credit_b = ((owner_q == OwnB) && ctr_winner) || ((owner_q == OwnA) && ctr_loser);
    a_sc_next = (credit_a && (a_score_q != ScoreMax)) ? a_score_q + SCORE_W'(1) : a_score_q;
    b_sc_next = (credit_b && (b_score_q != ScoreMax)) ? b_score_q + SCORE_W'(1) : b_score_q;
    match_end = ctr_gameover || (a_sc_next == ScoreMax) || (b_sc_next == ScoreMax);
    grant_a   = a_req && (!b_req || !rr_b_q);
    grant_b   = b_req && (!a_req || rr_b_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_b_d    = rr_b_q;
    a_gnt_d   = 1'b0;
    b_gnt_d   = 1'b0;
    ctrl_d    = ctrl_q;
    init_d    = 1'b0;
    load_d    = load_q;
    a_score_d = a_score_q;
    b_score_d = b_score_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    champ_d   = champ_q;

    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d   = StLoad;
          init_d    = 1'b1;
          load_d    = seed_value;
          a_score_d = '0;
          b_score_d = '0;
          owner_d   = OwnNone;
          champ_d   = OwnNone;
          busy_d    = 1'b1;
        end
      end

      StLoad: state_d = StArb;

      StArb, StTurn: begin
        a_score_d = a_sc_next;
        b_score_d = b_sc_next;
        if (match_end) begin
          // End of match wins over any grant or turn bookkeeping this cycle.
          state_d = StOver;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (a_sc_next > b_sc_next) begin
            champ_d = OwnA;
          end else if (b_sc_next > a_sc_next) begin
            champ_d = OwnB;
          end else begin
            champ_d = OwnTie;
          end
        end else if (state_q == StArb) begin
          if (a_req && b_req) begin
            rr_b_d = ~rr_b_q;
          end
          if (grant_a) begin
            a_gnt_d = 1'b1;
            ctrl_d  = a_mode;
            owner_d = OwnA;
          end else if (grant_b) begin
            b_gnt_d = 1'b1;
            ctrl_d  = b_mode;
            owner_d = OwnB;
          end
          if (grant_a || grant_b) begin
            cnt_d   = TurnLast;
            state_d = StTurn;
          end
        end else begin
          if (cnt_q == '0) begin
            state_d = StArb;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rr_b_q    <= 1'b0;
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
      ctrl_q    <= '0;
      init_q    <= 1'b0;
      load_q    <= '0;
      a_score_q <= '0;
      b_score_q <= '0;
      owner_q   <= OwnNone;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      champ_q   <= OwnNone;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_b_q    <= rr_b_d;
      a_gnt_q   <= a_gnt_d;
      b_gnt_q   <= b_gnt_d;
      ctrl_q    <= ctrl_d;
      init_q    <= init_d;
      load_q    <= load_d;
      a_score_q <= a_score_d;
      b_score_q <= b_score_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      champ_q   <= champ_d;
    end
  end

  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign ctr_ctrl = ctrl_q;
  assign ctr_init = init_q;
  assign ctr_load = load_q;
  assign a_score  = a_score_q;
  assign b_score  = b_score_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign champion = champ_q;

endmodule

// File: tb/tb_game_round_scheduler.sv
// Bench for game_round_scheduler: directed scenarios then random traffic, all outputs
// compared every cycle against a match-level reference model.
module tb_game_round_scheduler;

  localparam int unsigned CS = 4;
  localparam int unsigned TL = 4;
  localparam int unsigned SW = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_l, start, a_req, b_req, ctr_winner, ctr_loser, ctr_gameover;
  logic [CS-1:0] seed_value;
  logic [1:0]    a_mode, b_mode;
  logic          a_gnt, b_gnt, ctr_init, busy, done;
  logic [1:0]    ctr_ctrl, owner, champion;
  logic [CS-1:0] ctr_load;
  logic [SW-1:0] a_score, b_score;

  always #5 clk = ~clk;

  game_round_scheduler #(
    .COUNTER_SIZE(CS),
    .TURN_LEN    (TL),
    .SCORE_W     (SW)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .start       (start),
    .seed_value  (seed_value),
    .a_req       (a_req),
    .b_req       (b_req),
    .a_mode      (a_mode),
    .b_mode      (b_mode),
    .a_gnt       (a_gnt),
    .b_gnt       (b_gnt),
    .ctr_ctrl    (ctr_ctrl),
    .ctr_init    (ctr_init),
    .ctr_load    (ctr_load),
    .ctr_winner  (ctr_winner),
    .ctr_loser   (ctr_loser),
    .ctr_gameover(ctr_gameover),
    .a_score     (a_score),
    .b_score     (b_score),
    .owner       (owner),
    .busy        (busy),
    .done        (done),
    .champion    (champion)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: phase of the match, cycles left in the current turn, who the tie-break
  // favours next, and the expected value of every output.
  typedef enum int {PIdle, PLoad, PArb, PTurn, POver} phase_t;
  phase_t m_phase;
  int m_left, m_favour_b;
  int m_a, m_b, m_owner, m_ctrl, m_init, m_load, m_agnt, m_bgnt, m_busy, m_done, m_champ;

  function automatic int bump(input int s);
    return (s + 1 > SMAX) ? SMAX : s + 1;
  endfunction

  task automatic model_reset();
    m_phase = PIdle; m_left = 0; m_favour_b = 0;
    m_a = 0; m_b = 0; m_owner = 0; m_ctrl = 0; m_init = 0; m_load = 0;
    m_agnt = 0; m_bgnt = 0; m_busy = 0; m_done = 0; m_champ = 0;
  endtask

  task automatic model_step();
    int who;
    if (!rst_l) begin
      model_reset();
      return;
    end
    m_agnt = 0; m_bgnt = 0; m_init = 0; m_done = 0;
    case (m_phase)
      PIdle, POver: if (start) begin
        m_phase = PLoad; m_init = 1; m_load = int'(seed_value);
        m_a = 0; m_b = 0; m_owner = 0; m_champ = 0; m_busy = 1;
      end
      PLoad: m_phase = PArb;
      default: begin
        if (m_owner == 1) begin
          if (ctr_winner) m_a = bump(m_a);
          if (ctr_loser)  m_b = bump(m_b);
        end else if (m_owner == 2) begin
          if (ctr_winner) m_b = bump(m_b);
          if (ctr_loser)  m_a = bump(m_a);
        end
        if (ctr_gameover || m_a == SMAX || m_b == SMAX) begin
          m_phase = POver; m_busy = 0; m_done = 1;
          m_champ = (m_a > m_b) ? 1 : (m_b > m_a) ? 2 : 3;
        end else if (m_phase == PArb) begin
          who = 0;
          if (a_req && b_req) begin
            who = m_favour_b ? 2 : 1;
            m_favour_b = !m_favour_b;
          end else if (a_req) begin
            who = 1;
          end else if (b_req) begin
            who = 2;
          end
          if (who != 0) begin
            m_owner = who;
            m_ctrl  = (who == 1) ? int'(a_mode) : int'(b_mode);
            if (who == 1) m_agnt = 1; else m_bgnt = 1;
            m_left  = TL;
            m_phase = PTurn;
          end
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) m_phase = PArb;
        end
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a_gnt", a_gnt, m_agnt);
    check("b_gnt", b_gnt, m_bgnt);
    check("ctr_ctrl", ctr_ctrl, m_ctrl);
    check("ctr_init", ctr_init, m_init);
    check("ctr_load", ctr_load, m_load);
    check("a_score", a_score, m_a);
    check("b_score", b_score, m_b);
    check("owner", owner, m_owner);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("champion", champion, m_champ);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int g_t[$];
  int g_who[$];

  initial begin
    model_reset();
    rst_l = 1'b0; start = 1'b0; seed_value = '0; a_req = 1'b0; b_req = 1'b0;
    a_mode = 2'b00; b_mode = 2'b00; ctr_winner = 1'b0; ctr_loser = 1'b0; ctr_gameover = 1'b0;
    cyc(2);
    rst_l = 1'b1;
    cyc(1);

    // Build a_score=3 inside A's turn, then reset mid-turn.
    seed_value = 4'd9; start = 1'b1; cyc(1); start = 1'b0;
    cyc(1);
    a_req = 1'b1; cyc(1); a_req = 1'b0;
    check("grant_owner_a", owner, 1);
    ctr_winner = 1'b1; cyc(3); ctr_winner = 1'b0;
    check("pre_reset_score", a_score, 3);
    rst_l = 1'b0; cyc(1); rst_l = 1'b1;
    check("rst_a_score", a_score, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_ctrl", ctr_ctrl, 0);

    // Restart: ctr_init for exactly one cycle carrying the seed.
    start = 1'b1; cyc(1); start = 1'b0;
    check("init_on", ctr_init, 1);
    check("init_load", ctr_load, 9);
    check("init_busy", busy, 1);
    cyc(1);
    check("init_off", ctr_init, 0);

    // Lone B request with the pointer at A, then continuous contention.
    a_mode = 2'b00; b_mode = 2'b11;
    b_req = 1'b1; cyc(1);
    check("b_only_gnt", b_gnt, 1);
    check("b_only_ctrl", ctr_ctrl, 3);
    a_req = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      check("gnt_onehot", a_gnt & b_gnt, 0);
      if (a_gnt || b_gnt) begin
        g_t.push_back(i);
        g_who.push_back(a_gnt ? 1 : 2);
      end
    end
    check("gnt_count", g_t.size() >= 4, 1);
    if (g_t.size() > 0) check("gnt_first_a", g_who[0], 1);
    for (int k = 1; k < g_t.size(); k++) begin
      check("gnt_gap", g_t[k] - g_t[k-1], TL + 1);
      check("gnt_alt", g_who[k], (g_who[k-1] == 1) ? 2 : 1);
    end
    a_req = 1'b0; b_req = 1'b0;
    ctr_gameover = 1'b1; cyc(1); ctr_gameover = 1'b0;
    check("over_done", done, 1);
    check("over_tie0", champion, 3);
    cyc(1);
    check("done_pulse", done, 0);

    // Scoring rules, ignored flags without an owner, start while busy, tie at 3/3.
    start = 1'b1; cyc(1); start = 1'b0; cyc(1);
    ctr_winner = 1'b1; cyc(1); ctr_winner = 1'b0;
    ctr_loser = 1'b1; cyc(1); ctr_loser = 1'b0;
    check("noowner_a", a_score, 0);
    check("noowner_b", b_score, 0);
    a_mode = 2'b01; a_req = 1'b1; cyc(1); a_req = 1'b0;
    ctr_winner = 1'b1; cyc(1); ctr_winner = 1'b0;
    check("win_a", a_score, 1);
    ctr_loser = 1'b1; cyc(1); ctr_loser = 1'b0;
    check("lose_b", b_score, 1);
    start = 1'b1; cyc(1); start = 1'b0;
    check("busy_start_init", ctr_init, 0);
    check("busy_start_busy", busy, 1);
    ctr_winner = 1'b1; cyc(2); ctr_winner = 1'b0;
    ctr_loser = 1'b1; cyc(2); ctr_loser = 1'b0;
    check("tie_a", a_score, 3);
    check("tie_b", b_score, 3);
    ctr_gameover = 1'b1; cyc(1); ctr_gameover = 1'b0;
    check("tie_champ", champion, 3);
    check("tie_busy", busy, 0);
    check("tie_done", done, 1);

    // Saturation ends the match.
    start = 1'b1; cyc(1); start = 1'b0; cyc(1);
    a_req = 1'b1; cyc(1); a_req = 1'b0;
    ctr_winner = 1'b1; cyc(14);
    check("sat_14", a_score, 14);
    check("sat_14_busy", busy, 1);
    cyc(1);
    check("sat_15", a_score, 15);
    check("sat_done", done, 1);
    check("sat_champ", champion, 1);
    cyc(2); ctr_winner = 1'b0;
    ctr_loser = 1'b1; cyc(1); ctr_loser = 1'b0;
    check("sat_hold_a", a_score, 15);
    check("sat_hold_b", b_score, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_l        = ($urandom_range(0, 399) != 0);
      start        = ($urandom_range(0, 7) == 0);
      seed_value   = CS'($urandom);
      a_req        = $urandom_range(0, 1) == 1;
      b_req        = $urandom_range(0, 1) == 1;
      a_mode       = 2'($urandom);
      b_mode       = 2'($urandom);
      ctr_winner   = ($urandom_range(0, 9) == 0);
      ctr_loser    = ($urandom_range(0, 9) == 0);
      ctr_gameover = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
